// File: rtl/rom_load_packer.sv
// rom_load_packer: packs iosys loader bytes into SDRAM words, buffers them in a small
// FIFO and issues toggle req/ack writes; derives the core run enable and ROM size.
module rom_load_packer #(
  parameter int unsigned       ADDR_W     = 22,
  parameter int unsigned       DATA_W     = 16,
  parameter bit                BIG_ENDIAN = 1'b1,
  parameter int unsigned       FIFO_DEPTH = 4,
  parameter logic [ADDR_W-1:0] RAM_BASE   = ADDR_W'(32'h20000)
) (
  input  logic                                 clk,
  input  logic                                 resetn,
  input  logic [2:0]                           loading,
  input  logic [7:0]                           loader_do,
  input  logic                                 loader_do_valid,
  output logic [ADDR_W-$clog2(DATA_W/8)-1:0]   mem_addr,
  output logic [DATA_W-1:0]                    mem_wdata,
  output logic [DATA_W/8-1:0]                  mem_be,
  output logic                                 mem_req,
  input  logic                                 mem_ack,
  output logic                                 loader_busy,
  output logic                                 core_on,
  output logic [ADDR_W-1:0]                    rom_size,
  output logic                                 overflow
);

  localparam int unsigned BPW  = DATA_W / 8;
  localparam int unsigned BL   = $clog2(BPW);
  localparam int unsigned WA_W = ADDR_W - BL;
  localparam int unsigned PW   = $clog2(FIFO_DEPTH);
  localparam int unsigned CW   = PW + 1;
  localparam logic [WA_W-1:0] RAM_WBASE = WA_W'(RAM_BASE >> BL);

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_DRAIN} state_e;
  state_e state_q, state_d;

  logic              ld_act_c, ld_ram_c, switch_c, start_c, end_c, byte_c;
  logic              word_done_c, flush_c, push_c, push_ok_c, drop_c, pop_c;
  logic              fifo_empty_c, fifo_full_c, drain_done_c;
  logic [BL-1:0]     lane_c, plane_c;
  logic [DATA_W-1:0] pack_c, push_data_c;
  logic [BPW-1:0]    be_c, push_be_c;
  logic [WA_W-1:0]   push_addr_c;

  logic [ADDR_W-1:0] cnt_q, cnt_d, rom_size_q, rom_size_d;
  logic [DATA_W-1:0] pack_q, pack_d, mem_wdata_q, mem_wdata_d;
  logic [BPW-1:0]    pbe_q, pbe_d, mem_be_q, mem_be_d;
  logic [WA_W-1:0]   mem_addr_q, mem_addr_d;
  logic [CW-1:0]     fcnt_q, fcnt_d;
  logic [PW-1:0]     wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic              region_q, region_d, mem_req_q, mem_req_d, busy_q, busy_d;
  logic              core_on_q, core_on_d, ovf_q, ovf_d;

  logic [WA_W-1:0]   fifo_addr_q [FIFO_DEPTH];
  logic [DATA_W-1:0] fifo_data_q [FIFO_DEPTH];
  logic [BPW-1:0]    fifo_be_q   [FIFO_DEPTH];

  // Load region decode; a 1<->2 change is treated as end of one region plus start of another
  assign ld_act_c    = (loading == 3'd1) || (loading == 3'd2);
  assign ld_ram_c    = (loading == 3'd2);
  assign switch_c    = (state_q == S_LOAD) && ld_act_c && (ld_ram_c != region_q);
  assign start_c     = ((state_q == S_IDLE) && ld_act_c) || switch_c;
  assign end_c       = (state_q == S_LOAD) && !ld_act_c;
  assign byte_c      = (state_q == S_LOAD) && ld_act_c && !switch_c && loader_do_valid;
  assign lane_c      = cnt_q[BL-1:0];
  assign plane_c     = BIG_ENDIAN ? (BL'(BPW-1) - lane_c) : lane_c;
  assign word_done_c = byte_c && (lane_c == BL'(BPW-1));
  assign flush_c     = (end_c || switch_c) && (pbe_q != '0);

  assign fifo_empty_c = (fcnt_q == '0);
  assign fifo_full_c  = (fcnt_q == CW'(FIFO_DEPTH));
  assign pop_c        = !fifo_empty_c && (mem_req_q == mem_ack);
  assign push_c       = word_done_c || flush_c;
  assign push_ok_c    = push_c && (!fifo_full_c || pop_c);
  assign drop_c       = push_c && !push_ok_c;
  assign drain_done_c = (state_q == S_DRAIN) && fifo_empty_c && (mem_req_q == mem_ack);

  // Packer word with the incoming byte merged into its lane
  always_comb begin
    pack_c = pack_q;
    be_c   = pbe_q;
    pack_c[8*int'(plane_c) +: 8] = loader_do;
    be_c[plane_c] = 1'b1;
  end

  assign push_data_c = word_done_c ? pack_c : pack_q;
  assign push_be_c   = word_done_c ? '1 : pbe_q;
  assign push_addr_c = cnt_q[ADDR_W-1:BL] + (region_q ? RAM_WBASE : '0);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state_q <= S_IDLE;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:  if (ld_act_c) state_d = S_LOAD;
      S_LOAD:  if (!ld_act_c) state_d = S_DRAIN;
      S_DRAIN: if (drain_done_c) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    cnt_d       = cnt_q;
    pack_d      = pack_q;
    pbe_d       = pbe_q;
    region_d    = region_q;
    fcnt_d      = fcnt_q + CW'(push_ok_c) - CW'(pop_c);
    wr_ptr_d    = push_ok_c ? wr_ptr_q + PW'(1) : wr_ptr_q;
    rd_ptr_d    = pop_c ? rd_ptr_q + PW'(1) : rd_ptr_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    mem_be_d    = mem_be_q;
    mem_req_d   = mem_req_q;
    busy_d      = (fcnt_d >= CW'(FIFO_DEPTH - 1));
    core_on_d   = core_on_q;
    rom_size_d  = rom_size_q;
    ovf_d       = ovf_q;

    if (start_c) begin
      cnt_d     = '0;
      pack_d    = '0;
      pbe_d     = '0;
      region_d  = ld_ram_c;
      core_on_d = 1'b0;
      if (!ld_ram_c) ovf_d = 1'b0;
    end else if (end_c || word_done_c) begin
      pack_d = '0;
      pbe_d  = '0;
    end else if (byte_c) begin
      pack_d = pack_c;
      pbe_d  = be_c;
    end

    if (byte_c) begin
      cnt_d = cnt_q + ADDR_W'(1);
      if (cnt_q == {ADDR_W{1'b1}}) ovf_d = 1'b1;
    end
    if (drop_c) ovf_d = 1'b1;

    if (pop_c) begin
      mem_addr_d  = fifo_addr_q[rd_ptr_q];
      mem_wdata_d = fifo_data_q[rd_ptr_q];
      mem_be_d    = fifo_be_q[rd_ptr_q];
      mem_req_d   = ~mem_req_q;
    end

    // Core is released only after the last write of the load has been acknowledged
    if (drain_done_c) begin
      core_on_d = 1'b1;
      if (!region_q) rom_size_d = cnt_q;
    end
  end

  // Word storage carries no reset; validity is tracked by the occupancy counter
  always_ff @(posedge clk) begin
    if (push_ok_c) begin
      fifo_addr_q[wr_ptr_q] <= push_addr_c;
      fifo_data_q[wr_ptr_q] <= push_data_c;
      fifo_be_q[wr_ptr_q]   <= push_be_c;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      cnt_q       <= '0;
      pack_q      <= '0;
      pbe_q       <= '0;
      region_q    <= 1'b0;
      fcnt_q      <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_be_q    <= '0;
      mem_req_q   <= 1'b0;
      busy_q      <= 1'b0;
      core_on_q   <= 1'b0;
      rom_size_q  <= '0;
      ovf_q       <= 1'b0;
    end else begin
      cnt_q       <= cnt_d;
      pack_q      <= pack_d;
      pbe_q       <= pbe_d;
      region_q    <= region_d;
      fcnt_q      <= fcnt_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      mem_be_q    <= mem_be_d;
      mem_req_q   <= mem_req_d;
      busy_q      <= busy_d;
      core_on_q   <= core_on_d;
      rom_size_q  <= rom_size_d;
      ovf_q       <= ovf_d;
    end
  end

  assign mem_addr    = mem_addr_q;
  assign mem_wdata   = mem_wdata_q;
  assign mem_be      = mem_be_q;
  assign mem_req     = mem_req_q;
  assign loader_busy = busy_q;
  assign core_on     = core_on_q;
  assign rom_size    = rom_size_q;
  assign overflow    = ovf_q;

endmodule

// File: tb/tb_rom_load_packer.sv
// Directed bench for rom_load_packer: 16-bit big-endian and 32-bit little-endian instances,
// each with a fixed-latency toggle ack responder logging completed writes.
module tb_rom_load_packer;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic resetn;

  logic [2:0]  loading_a, loading_b;
  logic [7:0]  do_a, do_b;
  logic        valid_a, valid_b;
  logic [20:0] mem_addr_a;
  logic [19:0] mem_addr_b;
  logic [15:0] mem_wdata_a;
  logic [31:0] mem_wdata_b;
  logic [1:0]  mem_be_a;
  logic [3:0]  mem_be_b;
  logic        mem_req_a, mem_req_b, ack_a, ack_b;
  logic        busy_a, busy_b, core_on_a, core_on_b, ovf_a, ovf_b;
  logic [21:0] rom_size_a, rom_size_b;
  logic        hold_a;

  int n_vec = 0;
  int n_err = 0;
  logic [31:0] wa_addr[$], wa_data[$], wa_be[$];
  logic [31:0] wb_addr[$], wb_data[$], wb_be[$];

  rom_load_packer #(.ADDR_W(22), .DATA_W(16), .BIG_ENDIAN(1'b1), .FIFO_DEPTH(4),
                    .RAM_BASE(22'h20000)) u_a (
    .clk(clk), .resetn(resetn), .loading(loading_a), .loader_do(do_a),
    .loader_do_valid(valid_a), .mem_addr(mem_addr_a), .mem_wdata(mem_wdata_a),
    .mem_be(mem_be_a), .mem_req(mem_req_a), .mem_ack(ack_a), .loader_busy(busy_a),
    .core_on(core_on_a), .rom_size(rom_size_a), .overflow(ovf_a));

  rom_load_packer #(.ADDR_W(22), .DATA_W(32), .BIG_ENDIAN(1'b0), .FIFO_DEPTH(4),
                    .RAM_BASE(22'h20000)) u_b (
    .clk(clk), .resetn(resetn), .loading(loading_b), .loader_do(do_b),
    .loader_do_valid(valid_b), .mem_addr(mem_addr_b), .mem_wdata(mem_wdata_b),
    .mem_be(mem_be_b), .mem_req(mem_req_b), .mem_ack(ack_b), .loader_busy(busy_b),
    .core_on(core_on_b), .rom_size(rom_size_b), .overflow(ovf_b));

  // SDRAM model: acknowledges a request three cycles after it appears
  int dly_a = 0;
  always begin
    @(posedge clk); #1;
    if (!resetn) begin
      ack_a = 1'b0; dly_a = 0;
    end else if (mem_req_a !== ack_a && !hold_a) begin
      if (dly_a == 2) begin
        wa_addr.push_back(32'(mem_addr_a));
        wa_data.push_back(32'(mem_wdata_a));
        wa_be.push_back(32'(mem_be_a));
        ack_a = mem_req_a; dly_a = 0;
      end else dly_a++;
    end
  end

  int dly_b = 0;
  always begin
    @(posedge clk); #1;
    if (!resetn) begin
      ack_b = 1'b0; dly_b = 0;
    end else if (mem_req_b !== ack_b) begin
      if (dly_b == 2) begin
        wb_addr.push_back(32'(mem_addr_b));
        wb_data.push_back(32'(mem_wdata_b));
        wb_be.push_back(32'(mem_be_b));
        ack_b = mem_req_b; dly_b = 0;
      end else dly_b++;
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk); #2;
  endtask

  task automatic send_a(input logic [7:0] b);
    do_a = b; valid_a = 1'b1; step(); valid_a = 1'b0;
  endtask

  task automatic send_b(input logic [7:0] b);
    do_b = b; valid_b = 1'b1; step(); valid_b = 1'b0;
  endtask

  task automatic clear_a();
    wa_addr.delete(); wa_data.delete(); wa_be.delete();
  endtask

  task automatic wait_core_a(input string tag, input int exp_wr);
    int n = 0;
    while (core_on_a !== 1'b1 && n < 200) begin step(); n++; end
    chk({tag, "_core_on"}, 32'(core_on_a), 32'd1);
    chk({tag, "_writes_at_core_on"}, 32'(wa_addr.size()), 32'(exp_wr));
  endtask

  task automatic wait_core_b(input string tag, input int exp_wr);
    int n = 0;
    while (core_on_b !== 1'b1 && n < 200) begin step(); n++; end
    chk({tag, "_core_on"}, 32'(core_on_b), 32'd1);
    chk({tag, "_writes_at_core_on"}, 32'(wb_addr.size()), 32'(exp_wr));
  endtask

  task automatic chk_wr_a(input string tag, input int idx, input logic [31:0] addr,
                          input logic [31:0] data, input logic [31:0] mask,
                          input logic [31:0] be);
    logic ok;
    ok = idx < wa_addr.size();
    chk({tag, "_addr"}, ok ? wa_addr[idx] : 32'hDEAD_BEEF, addr);
    chk({tag, "_data"}, ok ? (wa_data[idx] & mask) : 32'hDEAD_BEEF, data);
    chk({tag, "_be"},   ok ? wa_be[idx] : 32'hDEAD_BEEF, be);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    resetn = 1'b0; hold_a = 1'b0;
    loading_a = 3'd0; do_a = 8'h00; valid_a = 1'b0;
    loading_b = 3'd0; do_b = 8'h00; valid_b = 1'b0;
    repeat (3) step();
    chk("rst_core_on", 32'(core_on_a), 32'd0);
    chk("rst_mem_req", 32'(mem_req_a), 32'd0);
    chk("rst_busy",    32'(busy_a),    32'd0);
    chk("rst_ovf",     32'(ovf_a),     32'd0);
    chk("rst_rom_size", 32'(rom_size_a), 32'd0);
    resetn = 1'b1;
    step();

    // T1: four bytes, two full big-endian words
    loading_a = 3'd1; step();
    send_a(8'h11); send_a(8'h22); send_a(8'h33); send_a(8'h44);
    loading_a = 3'd0; step();
    wait_core_a("t1", 2);
    chk_wr_a("t1_w0", 0, 32'h0, 32'h1122, 32'hFFFF, 32'h3);
    chk_wr_a("t1_w1", 1, 32'h1, 32'h3344, 32'hFFFF, 32'h3);
    chk("t1_rom_size", 32'(rom_size_a), 32'd4);

    // T3: 32-bit little-endian word
    loading_b = 3'd1; step();
    send_b(8'h01); send_b(8'h02); send_b(8'h03); send_b(8'h04);
    loading_b = 3'd0; step();
    wait_core_b("t3", 1);
    chk("t3_addr", wb_addr.size() > 0 ? wb_addr[0] : 32'hDEAD_BEEF, 32'h0);
    chk("t3_data", wb_data.size() > 0 ? wb_data[0] : 32'hDEAD_BEEF, 32'h04030201);
    chk("t3_be",   wb_be.size() > 0 ? wb_be[0] : 32'hDEAD_BEEF, 32'hF);
    chk("t3_rom_size", 32'(rom_size_b), 32'd4);

    // T2: three bytes, partial word flushed at load end
    clear_a();
    loading_a = 3'd1; step();
    chk("t2_core_off", 32'(core_on_a), 32'd0);
    send_a(8'hAA); send_a(8'hBB); send_a(8'hCC);
    loading_a = 3'd0; step();
    wait_core_a("t2", 2);
    chk_wr_a("t2_w0", 0, 32'h0, 32'hAABB, 32'hFFFF, 32'h3);
    chk_wr_a("t2_w1", 1, 32'h1, 32'hCC00, 32'hFF00, 32'h2);
    chk("t2_rom_size", 32'(rom_size_a), 32'd3);

    // T4: SDRAM stalled while bytes stream every cycle
    clear_a();
    hold_a = 1'b1;
    loading_a = 3'd1; step();
    for (int i = 0; i < 12; i++) begin
      send_a(8'(8'h50 + i));
      if (i == 5)  chk("t4_busy_at_2", 32'(busy_a), 32'd0);
      if (i == 7)  chk("t4_busy_at_3", 32'(busy_a), 32'd1);
      if (i == 9)  chk("t4_ovf_full",  32'(ovf_a),  32'd0);
      if (i == 11) chk("t4_ovf_drop",  32'(ovf_a),  32'd1);
    end
    repeat (28) step();
    hold_a = 1'b0;
    loading_a = 3'd0; step();
    wait_core_a("t4", 5);
    chk_wr_a("t4_w4", 4, 32'h4, 32'h5859, 32'hFFFF, 32'h3);
    chk("t4_ovf_sticky", 32'(ovf_a), 32'd1);
    chk("t4_rom_size", 32'(rom_size_a), 32'd12);

    // T5: ROM load switches to cart RAM mid-word
    resetn = 1'b0; step(); clear_a(); resetn = 1'b1; step();
    loading_a = 3'd1; step();
    send_a(8'h01); send_a(8'h02); send_a(8'h03); send_a(8'h04); send_a(8'h05);
    loading_a = 3'd2; step();
    chk("t5_core_off_switch", 32'(core_on_a), 32'd0);
    send_a(8'h06); send_a(8'h07); send_a(8'h08); send_a(8'h09);
    chk("t5_core_off_ram", 32'(core_on_a), 32'd0);
    loading_a = 3'd0; step();
    wait_core_a("t5", 5);
    chk_wr_a("t5_w0", 0, 32'h0, 32'h0102, 32'hFFFF, 32'h3);
    chk_wr_a("t5_w1", 1, 32'h1, 32'h0304, 32'hFFFF, 32'h3);
    chk_wr_a("t5_flush", 2, 32'h2, 32'h0500, 32'hFF00, 32'h2);
    chk_wr_a("t5_ram0", 3, 32'h10000, 32'h0607, 32'hFFFF, 32'h3);
    chk_wr_a("t5_ram1", 4, 32'h10001, 32'h0809, 32'hFFFF, 32'h3);
    chk("t5_rom_size", 32'(rom_size_a), 32'd0);
    chk("t5_ovf", 32'(ovf_a), 32'd0);

    // T6: reset with a request outstanding and the FIFO nearly full
    clear_a();
    hold_a = 1'b1;
    loading_a = 3'd1; step();
    for (int i = 0; i < 8; i++) send_a(8'(8'h70 + i));
    step();
    chk("t6_outstanding", 32'(mem_req_a ^ ack_a), 32'd1);
    chk("t6_busy_before", 32'(busy_a), 32'd1);
    resetn = 1'b0; #1;
    chk("t6_core_on", 32'(core_on_a), 32'd0);
    chk("t6_mem_req", 32'(mem_req_a), 32'd0);
    chk("t6_busy",    32'(busy_a),    32'd0);
    chk("t6_ovf",     32'(ovf_a),     32'd0);
    loading_a = 3'd0; hold_a = 1'b0;
    step(); step();
    clear_a();
    resetn = 1'b1; step();
    loading_a = 3'd1; step();
    send_a(8'h12); send_a(8'h34);
    loading_a = 3'd0; step();
    wait_core_a("t6", 1);
    chk_wr_a("t6_w0", 0, 32'h0, 32'h1234, 32'hFFFF, 32'h3);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
